// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the register file slice.
// Default geometry plus the occupancy-count width function.
package reg_file_pkg;

    localparam int DEF_WIDTH = 12;
    localparam int DEF_DEPTH = 8;

    // Bits needed to hold a count from 0 up to depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/reg_file_entry.sv
// One storage word plus its written flag.
// Clear beats load; reset is asynchronous.
module reg_file_entry
    import reg_file_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             vld
);

    // Word and flag: clear wipes both, load captures and marks written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q   <= '0;
            vld <= 1'b0;
        end else if (clr) begin
            q   <= '0;
            vld <= 1'b0;
        end else if (ld) begin
            q   <= d;
            vld <= 1'b1;
        end
    end

endmodule

// File: rtl/reg_file_nbit.sv
// Register file: one write port, two registered read ports,
// per-entry written flags and an occupancy count.
module reg_file_nbit
    import reg_file_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter bit BYPASS = 1'b1,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int CNT_W  = cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              ld,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en_a,
    input  logic              rd_en_b,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_a,
    output logic [WIDTH-1:0]  rd_data_b,
    output logic              rd_valid_a,
    output logic              rd_valid_b,
    output logic [DEPTH-1:0]  valid_mask,
    output logic [CNT_W-1:0]  count
);

    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] ld_vec;
    logic             wr_ok;
    logic             wr_fire;
    logic             new_bit;
    logic [WIDTH-1:0] nxt_data_a;
    logic [WIDTH-1:0] nxt_data_b;
    logic             nxt_vld_a;
    logic             nxt_vld_b;

    assign wr_ok   = ({1'b0, wr_addr} < DEPTH_V);
    assign wr_fire = ld && !clr && wr_ok;

    // One-hot write decode; out-of-range addresses select nothing.
    always_comb begin
        ld_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ld_vec[i] = wr_fire && (wr_addr == ADDR_W'(i));
        end
    end

    // A write lands on a previously unwritten entry.
    assign new_bit = |(ld_vec & ~valid_mask);

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        reg_file_entry #(
            .WIDTH (WIDTH)
        ) u_ent (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr),
            .ld    (ld_vec[g]),
            .d     (wr_data),
            .q     (mem[g]),
            .vld   (valid_mask[g])
        );
    end

    // Port A lookup: range check, storage, then same-edge write bypass.
    always_comb begin
        nxt_data_a = '0;
        nxt_vld_a  = 1'b0;
        if ({1'b0, rd_addr_a} < DEPTH_V) begin
            nxt_data_a = mem[rd_addr_a];
            nxt_vld_a  = valid_mask[rd_addr_a];
        end
        if (BYPASS && wr_fire && (wr_addr == rd_addr_a)) begin
            nxt_data_a = wr_data;
            nxt_vld_a  = 1'b1;
        end
    end

    // Port B lookup: same rules as port A.
    always_comb begin
        nxt_data_b = '0;
        nxt_vld_b  = 1'b0;
        if ({1'b0, rd_addr_b} < DEPTH_V) begin
            nxt_data_b = mem[rd_addr_b];
            nxt_vld_b  = valid_mask[rd_addr_b];
        end
        if (BYPASS && wr_fire && (wr_addr == rd_addr_b)) begin
            nxt_data_b = wr_data;
            nxt_vld_b  = 1'b1;
        end
    end

    // Read output registers capture only when enabled, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_a  <= '0;
            rd_valid_a <= 1'b0;
            rd_data_b  <= '0;
            rd_valid_b <= 1'b0;
        end else begin
            if (rd_en_a) begin
                rd_data_a  <= nxt_data_a;
                rd_valid_a <= nxt_vld_a;
            end
            if (rd_en_b) begin
                rd_data_b  <= nxt_data_b;
                rd_valid_b <= nxt_vld_b;
            end
        end
    end

    // Occupancy tracks first writes only; rewrites leave it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (new_bit) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_reg_file_nbit.sv
// Directed bench for reg_file_nbit: default, no-bypass and
// DEPTH=6 instances share one stimulus stream.
module tb_reg_file_nbit;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        ld;
    logic [2:0]  wr_addr;
    logic [11:0] wr_data;
    logic        rd_en_a;
    logic        rd_en_b;
    logic [2:0]  rd_addr_a;
    logic [2:0]  rd_addr_b;

    logic [11:0] m_da, m_db, n_da, n_db, s_da, s_db;
    logic        m_va, m_vb, n_va, n_vb, s_va, s_vb;
    logic [7:0]  m_mask, n_mask;
    logic [5:0]  s_mask;
    logic [3:0]  m_cnt, n_cnt;
    logic [2:0]  s_cnt;

    int checks;
    int errors;

    reg_file_nbit #(.WIDTH(12), .DEPTH(8), .BYPASS(1'b1)) u_main (
        .clk(clk), .rst_n(rst_n), .clr(clr), .ld(ld),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en_a(rd_en_a), .rd_en_b(rd_en_b),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(m_da), .rd_data_b(m_db),
        .rd_valid_a(m_va), .rd_valid_b(m_vb),
        .valid_mask(m_mask), .count(m_cnt)
    );

    reg_file_nbit #(.WIDTH(12), .DEPTH(8), .BYPASS(1'b0)) u_nb (
        .clk(clk), .rst_n(rst_n), .clr(clr), .ld(ld),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en_a(rd_en_a), .rd_en_b(rd_en_b),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(n_da), .rd_data_b(n_db),
        .rd_valid_a(n_va), .rd_valid_b(n_vb),
        .valid_mask(n_mask), .count(n_cnt)
    );

    reg_file_nbit #(.WIDTH(12), .DEPTH(6), .BYPASS(1'b1)) u_d6 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .ld(ld),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en_a(rd_en_a), .rd_en_b(rd_en_b),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(s_da), .rd_data_b(s_db),
        .rd_valid_a(s_va), .rd_valid_b(s_vb),
        .valid_mask(s_mask), .count(s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [11:0] d);
        ld      = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        ld = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        clr       = 1'b0;
        ld        = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_en_a   = 1'b0;
        rd_en_b   = 1'b0;
        rd_addr_a = '0;
        rd_addr_b = '0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        chk("rst_cnt", 32'(m_cnt), 0);
        chk("rst_mask", 32'(m_mask), 0);
        chk("rst_da", 32'(m_da), 0);
        chk("rst_va", 32'(m_va), 0);

        // write then read
        wr(3'd2, 12'hABC);
        chk("wr_cnt", 32'(m_cnt), 1);
        chk("wr_mask", 32'(m_mask), 32'h04);
        rd_en_a = 1'b1; rd_addr_a = 3'd2;
        rd_en_b = 1'b1; rd_addr_b = 3'd3;
        step();
        rd_en_a = 1'b0; rd_en_b = 1'b0;
        chk("rd_da", 32'(m_da), 32'hABC);
        chk("rd_va", 32'(m_va), 1);
        chk("rd_unw_db", 32'(m_db), 0);
        chk("rd_unw_vb", 32'(m_vb), 0);
        wr(3'd2, 12'h123);
        chk("rewr_cnt", 32'(m_cnt), 1);

        // collision
        wr(3'd5, 12'h0FF);
        ld = 1'b1; wr_addr = 3'd5; wr_data = 12'h055;
        rd_en_b = 1'b1; rd_addr_b = 3'd5;
        step();
        ld = 1'b0;
        chk("col_byp_db", 32'(m_db), 32'h055);
        chk("col_byp_vb", 32'(m_vb), 1);
        chk("col_nb_db", 32'(n_db), 32'h0FF);
        chk("col_nb_vb", 32'(n_vb), 1);
        step();
        rd_en_b = 1'b0;
        chk("wtr_nb_db", 32'(n_db), 32'h055);
        chk("col_cnt", 32'(m_cnt), 2);

        // clr + ld with pre-clear read
        wr(3'd0, 12'h010);
        wr(3'd1, 12'h011);
        wr(3'd3, 12'h013);
        chk("pre_clr_cnt", 32'(m_cnt), 5);
        chk("pre_clr_mask", 32'(m_mask), 32'h2F);
        clr = 1'b1; ld = 1'b1; wr_addr = 3'd1; wr_data = 12'h777;
        rd_en_a = 1'b1; rd_addr_a = 3'd1;
        step();
        clr = 1'b0; ld = 1'b0;
        chk("clr_cnt", 32'(m_cnt), 0);
        chk("clr_mask", 32'(m_mask), 0);
        chk("clr_rd_da", 32'(m_da), 32'h011);
        chk("clr_rd_va", 32'(m_va), 1);
        step();
        chk("post_clr_da", 32'(m_da), 0);
        chk("post_clr_va", 32'(m_va), 0);
        rd_en_a = 1'b0;

        // out-of-range on DEPTH=6
        wr(3'd7, 12'h5A5);
        chk("oor_wr_s_cnt", 32'(s_cnt), 0);
        chk("oor_wr_s_mask", 32'(s_mask), 0);
        chk("oor_wr_m_mask", 32'(m_mask), 32'h80);
        wr(3'd4, 12'h444);
        rd_en_a = 1'b1; rd_addr_a = 3'd4;
        step();
        chk("s_rd4_da", 32'(s_da), 32'h444);
        chk("s_cnt1", 32'(s_cnt), 1);
        rd_addr_a = 3'd6;
        rd_en_b = 1'b1; rd_addr_b = 3'd7;
        step();
        rd_en_a = 1'b0; rd_en_b = 1'b0;
        chk("oor_rd_s_da", 32'(s_da), 0);
        chk("oor_rd_s_va", 32'(s_va), 0);
        chk("oor_rd_s_db", 32'(s_db), 0);
        chk("m_rd7_db", 32'(m_db), 32'h5A5);
        chk("m_rd7_vb", 32'(m_vb), 1);

        // fill everything
        for (int i = 0; i < 8; i++) begin
            wr(3'(i), 12'h100 + 12'(i));
        end
        chk("full_m_cnt", 32'(m_cnt), 8);
        chk("full_m_mask", 32'(m_mask), 32'hFF);
        chk("full_s_cnt", 32'(s_cnt), 6);
        chk("full_s_mask", 32'(s_mask), 32'h3F);
        chk("full_n_cnt", 32'(n_cnt), 8);
        rd_en_a = 1'b1; rd_addr_a = 3'd7;
        step();
        chk("full_rd7", 32'(m_da), 32'h107);
        rd_en_a = 1'b0; rd_addr_a = 3'd0;
        ld = 1'b1; wr_addr = 3'd7; wr_data = 12'hFFF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_da", 32'(m_da), 32'h107);
        end
        ld = 1'b0;

        // async reset between edges
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cnt", 32'(m_cnt), 0);
        chk("arst_mask", 32'(m_mask), 0);
        chk("arst_da", 32'(m_da), 0);
        chk("arst_vb", 32'(m_vb), 0);
        chk("arst_s_cnt", 32'(s_cnt), 0);
        step();
        chk("arst_hold", 32'(m_mask), 0);
        rst_n = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
